// File: rtl/tx_block_sched.sv
// Round-robin two-requester scheduler that splits each 128-bit block into four 32-bit words for a byte transmitter.
// Handshake in cycle n gives tx_start in cycle n+1; requesters only see ready while IDLE, so they wait out whole frames.
module tx_block_sched #(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [127:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [127:0] req1_data,
  output logic         req1_ready,
  output logic [31:0]  tx_data,
  output logic         tx_start,
  input  logic         tx_done,
  output logic         busy,
  output logic         grant,
  output logic         frame_done,
  output logic         err_timeout,
  input  logic         err_clr
);

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

  state_t        r_state;
  logic [127:0]  r_blk;
  logic [1:0]    r_idx;
  logic [15:0]   r_cnt;
  logic [31:0]   r_tx_data;
  logic          r_tx_start;
  logic          r_grant;
  logic          r_frame_done;
  logic          r_err;

  logic          w_idle;
  logic          w_pick1;
  logic          w_rdy0;
  logic          w_rdy1;
  logic [127:0]  w_win_blk;
  logic [16:0]   w_cnt_inc;
  logic          w_timeout;
  logic          w_gap_end;
  logic [1:0]    w_idx_nxt;
  logic [31:0]   w_word_nxt;

  // Requester 1 wins when it is the only one asking, or when requester 0 was served last.
  assign w_idle     = (r_state == IDLE) && rst;
  assign w_pick1    = req1_valid && (!req0_valid || !r_grant);
  assign w_rdy1     = w_idle && w_pick1;
  assign w_rdy0     = w_idle && req0_valid && !w_pick1;
  assign w_win_blk  = w_pick1 ? req1_data : req0_data;

  // r_cnt in WAIT holds cycles elapsed since tx_start; in GAP it holds gap cycles already spent.
  assign w_cnt_inc  = {1'b0, r_cnt} + 17'd1;
  assign w_timeout  = (w_cnt_inc == 17'(TIMEOUT_CYCLES));
  assign w_gap_end  = (w_cnt_inc == 17'(GAP_CYCLES));
  assign w_idx_nxt  = r_idx + 2'd1;
  assign w_word_nxt = r_blk[{w_idx_nxt, 5'd0} +: 32];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_blk        <= '0;
      r_idx        <= 2'd0;
      r_cnt        <= 16'd0;
      r_tx_data    <= 32'd0;
      r_tx_start   <= 1'b0;
      r_grant      <= 1'b1;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_tx_start   <= 1'b0;
      r_frame_done <= 1'b0;
      if (err_clr) begin
        r_err <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_rdy0 || w_rdy1) begin
            r_blk      <= w_win_blk;
            r_grant    <= w_pick1;
            r_idx      <= 2'd0;
            r_cnt      <= 16'd0;
            r_tx_data  <= w_win_blk[31:0];
            r_tx_start <= 1'b1;
            r_state    <= START;
          end
        end
        START: begin
          r_cnt   <= 16'd1;
          r_state <= WAIT;
        end
        WAIT: begin
          // tx_done is checked before the timeout so a completion on the deadline still counts.
          if (tx_done) begin
            r_cnt <= 16'd0;
            if (r_idx == 2'd3) begin
              r_frame_done <= 1'b1;
              r_state      <= IDLE;
            end else if (GAP_CYCLES == 0) begin
              r_idx      <= w_idx_nxt;
              r_tx_data  <= w_word_nxt;
              r_tx_start <= 1'b1;
              r_state    <= START;
            end else begin
              r_state <= GAP;
            end
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_cnt   <= 16'd0;
            r_state <= IDLE;
          end else begin
            r_cnt <= w_cnt_inc[15:0];
          end
        end
        GAP: begin
          if (w_gap_end) begin
            r_cnt      <= 16'd0;
            r_idx      <= w_idx_nxt;
            r_tx_data  <= w_word_nxt;
            r_tx_start <= 1'b1;
            r_state    <= START;
          end else begin
            r_cnt <= w_cnt_inc[15:0];
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req0_ready  = w_rdy0;
  assign req1_ready  = w_rdy1;
  assign tx_data     = r_tx_data;
  assign tx_start    = r_tx_start;
  assign busy        = (r_state != IDLE);
  assign grant       = r_grant;
  assign frame_done  = r_frame_done;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_tx_block_sched.sv
// Directed bench: dut_a (gap 16, timeout 100) covers framing, round-robin, timeout and reset abort;
// dut_b (gap 0, timeout 100) covers back-to-back words and tx_done landing on the timeout cycle.
module tb_tx_block_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic         a_req0_valid, a_req1_valid, a_req0_ready, a_req1_ready;
  logic [127:0] a_req0_data, a_req1_data;
  logic [31:0]  a_tx_data;
  logic         a_tx_start, a_tx_done, a_busy, a_grant, a_frame_done, a_err, a_err_clr;

  logic         b_req0_valid, b_req1_valid, b_req0_ready, b_req1_ready;
  logic [127:0] b_req0_data, b_req1_data;
  logic [31:0]  b_tx_data;
  logic         b_tx_start, b_tx_done, b_busy, b_grant, b_frame_done, b_err, b_err_clr;

  tx_block_sched #(.GAP_CYCLES(16), .TIMEOUT_CYCLES(100)) dut_a (
    .clk(clk), .rst(rst),
    .req0_valid(a_req0_valid), .req0_data(a_req0_data), .req0_ready(a_req0_ready),
    .req1_valid(a_req1_valid), .req1_data(a_req1_data), .req1_ready(a_req1_ready),
    .tx_data(a_tx_data), .tx_start(a_tx_start), .tx_done(a_tx_done),
    .busy(a_busy), .grant(a_grant), .frame_done(a_frame_done),
    .err_timeout(a_err), .err_clr(a_err_clr)
  );

  tx_block_sched #(.GAP_CYCLES(0), .TIMEOUT_CYCLES(100)) dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_ready(b_req0_ready),
    .req1_valid(b_req1_valid), .req1_data(b_req1_data), .req1_ready(b_req1_ready),
    .tx_data(b_tx_data), .tx_start(b_tx_start), .tx_done(b_tx_done),
    .busy(b_busy), .grant(b_grant), .frame_done(b_frame_done),
    .err_timeout(b_err), .err_clr(b_err_clr)
  );

  int total = 0;
  int bad = 0;
  int a_starts = 0, a_fd = 0, b_starts = 0, b_fd = 0;
  logic [127:0] d0, d1, d2;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and tally the pulse outputs seen there.
  task automatic step();
    @(negedge clk);
    if (a_tx_start)   a_starts++;
    if (a_frame_done) a_fd++;
    if (b_tx_start)   b_starts++;
    if (b_frame_done) b_fd++;
  endtask

  task automatic wait_start_a(input int budget, output int n);
    n = -1;
    for (int k = 1; k <= budget && n < 0; k++) begin
      step();
      if (a_tx_start) n = k;
    end
  endtask

  // Entered on the cycle dut_a shows tx_start for word 0; leaves on the cycle after the last tx_done.
  task automatic run_frame_a(input logic [127:0] blk, input logic exp_grant, input bit glitch, input string tag);
    int rdy_n;
    int k_hit;
    rdy_n = 0;
    chk($sformatf("%s:grant", tag), a_grant, exp_grant);
    for (int w = 0; w < 4; w++) begin
      chk($sformatf("%s:data_w%0d", tag, w), a_tx_data, blk[32*w +: 32]);
      repeat (20) begin
        step();
        if (a_req0_ready | a_req1_ready) rdy_n++;
      end
      a_tx_done = 1'b1;
      step();
      a_tx_done = 1'b0;
      if (w < 3) begin
        k_hit = -1;
        for (int k = 1; k <= 40 && k_hit < 0; k++) begin
          if (glitch && w == 0 && k == 5) a_tx_done = 1'b1;
          step();
          a_tx_done = 1'b0;
          if (a_req0_ready | a_req1_ready) rdy_n++;
          if (a_tx_start) k_hit = k;
        end
        chk($sformatf("%s:spacing_w%0d", tag, w), (k_hit < 0) ? -1 : k_hit + 1, 17);
      end else begin
        chk($sformatf("%s:frame_done", tag), a_frame_done, 1'b1);
        chk($sformatf("%s:busy_end", tag), a_busy, 1'b0);
      end
    end
    chk($sformatf("%s:ready_quiet", tag), rdy_n, 0);
  endtask

  initial begin
    int n;
    int s0;
    int f0;
    d0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    d1 = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
    d2 = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
    rst = 1'b0;
    a_req0_valid = 1'b1; a_req1_valid = 1'b0; a_req0_data = d0; a_req1_data = '0;
    a_tx_done = 1'b0; a_err_clr = 1'b0;
    b_req0_valid = 1'b0; b_req1_valid = 1'b0; b_req0_data = d2; b_req1_data = '0;
    b_tx_done = 1'b0; b_err_clr = 1'b0;

    // Reset state, with a requester already asking.
    repeat (3) step();
    chk("rst:busy", a_busy, 1'b0);
    chk("rst:tx_start", a_tx_start, 1'b0);
    chk("rst:tx_data", a_tx_data, 32'd0);
    chk("rst:frame_done", a_frame_done, 1'b0);
    chk("rst:err", a_err, 1'b0);
    chk("rst:grant", a_grant, 1'b1);
    chk("rst:req0_ready", a_req0_ready, 1'b0);
    chk("rst:b_grant", b_grant, 1'b1);

    // Single frame from requester 0, with a stray tx_done during the first gap.
    rst = 1'b1;
    #1;
    chk("f0:req0_ready", a_req0_ready, 1'b1);
    chk("f0:req1_ready", a_req1_ready, 1'b0);
    step();
    chk("f0:latency", a_tx_start, 1'b1);
    a_req0_valid = 1'b0;
    run_frame_a(d0, 1'b0, 1'b1, "f0");
    chk("f0:starts", a_starts, 4);
    chk("f0:fd_count", a_fd, 1);
    step();
    chk("f0:fd_pulse", a_frame_done, 1'b0);

    // Timeout: requester 1, tx_done never arrives.
    a_req1_data = d1;
    a_req1_valid = 1'b1;
    #1;
    chk("to:req1_ready", a_req1_ready, 1'b1);
    chk("to:req0_ready", a_req0_ready, 1'b0);
    step();
    chk("to:tx_start", a_tx_start, 1'b1);
    chk("to:tx_data", a_tx_data, d1[31:0]);
    chk("to:grant", a_grant, 1'b1);
    a_req1_valid = 1'b0;
    repeat (99) step();
    chk("to:err_early", a_err, 1'b0);
    chk("to:busy_early", a_busy, 1'b1);
    step();
    chk("to:err_set", a_err, 1'b1);
    chk("to:busy", a_busy, 1'b0);
    chk("to:frame_done", a_frame_done, 1'b0);
    s0 = a_starts;
    f0 = a_fd;
    repeat (10) step();
    chk("to:no_start", a_starts, s0);
    chk("to:no_fd", a_fd, f0);
    chk("to:sticky", a_err, 1'b1);
    a_err_clr = 1'b1;
    step();
    a_err_clr = 1'b0;
    chk("to:err_clr", a_err, 1'b0);

    // Round-robin with both requesters valid from reset.
    rst = 1'b0;
    a_req0_valid = 1'b1;
    a_req1_valid = 1'b1;
    a_req0_data = d0;
    repeat (2) step();
    chk("rr:rst_ready0", a_req0_ready, 1'b0);
    chk("rr:rst_ready1", a_req1_ready, 1'b0);
    chk("rr:rst_grant", a_grant, 1'b1);
    rst = 1'b1;
    #1;
    chk("rr:ready0", a_req0_ready, 1'b1);
    chk("rr:ready1", a_req1_ready, 1'b0);
    step();
    chk("rr:start0", a_tx_start, 1'b1);
    run_frame_a(d0, 1'b0, 1'b0, "rr0");
    for (int f = 1; f < 4; f++) begin
      wait_start_a(5, n);
      chk($sformatf("rr%0d:restart", f), n, 1);
      run_frame_a((f % 2 == 1) ? d1 : d0, (f % 2 == 1), 1'b0, $sformatf("rr%0d", f));
    end

    // Reset in the gap after word 1 of the next requester-0 frame.
    wait_start_a(5, n);
    chk("ra:start", n, 1);
    chk("ra:grant", a_grant, 1'b0);
    chk("ra:w0", a_tx_data, d0[31:0]);
    repeat (20) step();
    a_tx_done = 1'b1;
    step();
    a_tx_done = 1'b0;
    wait_start_a(40, n);
    chk("ra:w1", a_tx_data, d0[63:32]);
    repeat (20) step();
    a_tx_done = 1'b1;
    step();
    a_tx_done = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    a_req0_valid = 1'b0;
    a_req1_valid = 1'b0;
    step();
    chk("ra:busy", a_busy, 1'b0);
    chk("ra:tx_start", a_tx_start, 1'b0);
    chk("ra:grant_rst", a_grant, 1'b1);
    chk("ra:tx_data", a_tx_data, 32'd0);
    step();
    rst = 1'b1;
    s0 = a_starts;
    f0 = a_fd;
    repeat (30) step();
    chk("ra:no_start", a_starts, s0);
    chk("ra:no_fd", a_fd, f0);
    a_req1_valid = 1'b1;
    wait_start_a(5, n);
    chk("ra:new_start", n, 1);
    a_req1_valid = 1'b0;
    run_frame_a(d1, 1'b1, 1'b0, "ra_new");

    // Zero gap: each tx_done is followed next cycle by tx_start; last tx_done lands on the timeout cycle.
    b_req0_valid = 1'b1;
    step();
    chk("zg:start", b_tx_start, 1'b1);
    chk("zg:w0", b_tx_data, d2[31:0]);
    b_req0_valid = 1'b0;
    for (int w = 0; w < 3; w++) begin
      repeat (10) step();
      b_tx_done = 1'b1;
      step();
      b_tx_done = 1'b0;
      chk($sformatf("zg:next_start_w%0d", w + 1), b_tx_start, 1'b1);
      chk($sformatf("zg:data_w%0d", w + 1), b_tx_data, d2[32*(w+1) +: 32]);
    end
    repeat (99) step();
    chk("zg:err_before", b_err, 1'b0);
    chk("zg:busy_before", b_busy, 1'b1);
    b_tx_done = 1'b1;
    step();
    b_tx_done = 1'b0;
    chk("zg:frame_done", b_frame_done, 1'b1);
    chk("zg:err", b_err, 1'b0);
    chk("zg:busy", b_busy, 1'b0);
    chk("zg:starts", b_starts, 4);
    chk("zg:fd_count", b_fd, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_block_sched.md
TX_BLOCK_SCHED -- requirements
Module: tx_block_sched

Interface
Parameters:
REQ-001 The block SHALL have parameter GAP_CYCLES, default 16: idle clock cycles inserted between consecutive words of one frame (0 allowed).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 65535: maximum cycles to wait for tx_done after a tx_start (16-bit counter).

Ports:
REQ-003 The block SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: one clock; reset is synchronous and active-low.
REQ-005 The block SHALL have port req0_valid, input, 1: requester 0 has a 128-bit block to send.
REQ-006 The block SHALL have port req0_data, input, 128: requester 0 block.
REQ-007 The block SHALL have port req0_ready, output, 1: requester 0 block accepted this cycle when req0_valid is also high.
REQ-008 The block SHALL have ports req1_valid, req1_data and req1_ready, with the same directions and widths as requester 0.
REQ-009 The block SHALL have port tx_data, output, 32: word presented to the byte transmitter.
REQ-010 The block SHALL have port tx_start, output, 1: one-cycle pulse that starts transmission of tx_data.
REQ-011 The block SHALL have port tx_done, input, 1: one-cycle pulse from the transmitter after its stop bit.
REQ-012 The block SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-013 The block SHALL have port grant, output, 1: index of the requester being served, or last served.
REQ-014 The block SHALL have port frame_done, output, 1: one-cycle pulse when all 4 words are sent.
REQ-015 The block SHALL have port err_timeout, output, 1: sticky timeout flag.
REQ-016 The block SHALL have port err_clr, input, 1: clears err_timeout.

Function
REQ-017 The FSM SHALL have the states IDLE, START, WAIT and GAP.
REQ-018 In IDLE, the block SHALL assert ready combinationally to at most one requester, chosen by round-robin.
- Only one valid: that requester wins.
- Both valid: the requester other than grant wins.
REQ-019 On a valid&ready handshake, the block SHALL register the 128-bit block and set grant to the winner, word index = 0, next state START.
REQ-020 req*_ready SHALL be 0 in every state except IDLE.
REQ-021 In START, the block SHALL assert tx_start for exactly 1 cycle with tx_data = block[32*idx+31 : 32*idx], then go to WAIT.
- Word 0 is bits 31:0 and is sent first.
- Latency: handshake in cycle n gives tx_start in cycle n+1.
REQ-022 tx_data SHALL hold its value from START until the next START, or until return to IDLE.
REQ-023 In WAIT, the block SHALL increment the timeout counter each cycle.
- On tx_done with idx<3: go to GAP, clear the counter.
- On tx_done with idx==3: pulse frame_done, go to IDLE.
REQ-024 If the WAIT counter reaches TIMEOUT_CYCLES without tx_done, the block SHALL set err_timeout, discard the rest of the frame, go to IDLE, and not pulse frame_done.
REQ-025 If tx_done and the timeout occur in the same cycle, tx_done SHALL take priority.
REQ-026 In GAP, the block SHALL count GAP_CYCLES cycles, then increment idx and go to START.
- GAP_CYCLES=0: GAP lasts 0 cycles; WAIT goes directly to START.
REQ-027 The block SHALL ignore tx_done in every state except WAIT.
REQ-028 The index SHALL be 2 bits and SHALL never wrap inside a frame; idx==3 completion returns to IDLE.
REQ-029 err_clr SHALL clear err_timeout on the next edge; if err_clr and a new timeout occur in the same cycle, set SHALL win.

Reset
REQ-030 When rst==0 at a clock edge, the block SHALL set: state=IDLE, idx=0, counters=0, tx_start=0, tx_data=0, frame_done=0, err_timeout=0, busy=0, grant=1 (so requester 0 wins first).
REQ-031 Reset asserted mid-frame SHALL abort the frame with no frame_done and no further tx_start; the held block SHALL be discarded.
REQ-032 req*_ready SHALL be 0 while rst==0.

Verification
REQ-033 The bench SHALL drive req0 with data 0x00112233_44556677_8899AABB_CCDDEEFF and tx_done 20 cycles after each tx_start, with GAP_CYCLES=16.
- Required: 4 tx_start pulses with tx_data 0xCCDDEEFF, 0x8899AABB, 0x44556677, 0x00112233.
- Required: spacing from tx_done to the next tx_start = 17 cycles.
- Required: frame_done pulse exactly once.
REQ-034 The bench SHALL hold req0 and req1 both valid continuously from reset.
- Required grant order: 0, 1, 0, 1.
- Required: req1_ready stays 0 while frame 0 is sent.
REQ-035 The bench SHALL never drive tx_done, with TIMEOUT_CYCLES=100.
- Required: err_timeout=1 exactly 100 cycles after the first tx_start.
- Required: busy=0 and no frame_done.
- Then err_clr=1 -> err_timeout=0.
REQ-036 The bench SHALL assert rst=0 during GAP after word 1.
- Required: IDLE next cycle and no further tx_start.
- After release, a new req1 frame SHALL start from word 0.
REQ-037 With GAP_CYCLES=0, the bench SHALL pulse tx_done in the same cycle the timeout is reached on word 3.
- Required: frame_done=1 and err_timeout=0.
- Required: tx_start follows each tx_done by exactly 1 cycle.
